// File: rtl/note_sprite_renderer.sv
// Note sprite renderer: a 16-slot note buffer with a two-stage pixel pipeline
// that looks up 8x8 glyph rows from an external ROM, plus a slot-clearing FSM.
module note_sprite_renderer #(
    parameter int unsigned STAFF_X0 = 64,
    parameter int unsigned STAFF_Y0 = 128
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_valid,
    input  logic       wr_en,
    input  logic [3:0] wr_slot,
    input  logic [2:0] wr_code,
    input  logic [3:0] wr_pitch,
    input  logic       clr_start,
    output logic       busy,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       note_on,
    output logic       note_valid
);

    localparam int unsigned N_SLOTS = 16;
    localparam int unsigned SLOT_W  = 4;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned PITCH_W = 4;
    localparam int unsigned DX_W    = 11;
    localparam int unsigned DY_W    = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SLOT_W-1:0]   clr_cnt;
    logic [SLOT_W-1:0]   clr_cnt_next;

    logic [CODE_W-1:0]   note_code  [N_SLOTS];
    logic [PITCH_W-1:0]  note_pitch [N_SLOTS];

    logic [DX_W-1:0]     dx;
    logic [DY_W-1:0]     dy;
    logic [SLOT_W-1:0]   slot;
    logic [4:0]          dx_lo;
    logic                in_range;
    logic                col_ok;
    logic                row_ok;
    logic [2:0]          col;
    logic [CODE_W-1:0]   sel_code;
    logic [PITCH_W-1:0]  sel_pitch;
    logic                hit;
    logic                wr_ok;

    logic                s1_hit;
    logic                s1_valid;
    logic [CODE_W-1:0]   s1_code;
    logic [2:0]          s1_row;
    logic [2:0]          s1_col;

    // Stage-1 address decode: horizontal slot/column, then row against the slot's pitch
    always_comb begin
        dx        = DX_W'(DrawX) - DX_W'(STAFF_X0);
        in_range  = (dx[DX_W-1:9] == 2'b00);
        slot      = dx[8:5];
        dx_lo     = dx[4:0];
        col_ok    = (dx_lo >= 5'd12) && (dx_lo <= 5'd19);
        // (dx_lo - 12) mod 8 reduces to dx_lo[2:0] - 4
        col       = 3'(dx_lo[2:0] - 3'd4);
        sel_code  = note_code[slot];
        sel_pitch = note_pitch[slot];
        dy        = DY_W'(DrawY) - DY_W'(STAFF_Y0) - DY_W'({sel_pitch, 2'b00});
        row_ok    = (dy[DY_W-1:3] == '0);
        hit       = pix_valid & in_range & col_ok & row_ok & (sel_code != '0);
    end

    // Clear FSM next-state: walk the counter through all 16 slots, then return idle
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        wr_ok        = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt_next = '0;
                wr_ok        = wr_en & ~clr_start;
                if (clr_start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_cnt_next = SLOT_W'(clr_cnt + 4'd1);
                if (clr_cnt == 4'd15) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Clear FSM state, counter and busy flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            busy    <= (state_next == CLEAR);
        end
    end

    // Note buffer: cleared one slot per cycle during CLEAR, otherwise host writes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                note_code[i]  <= '0;
                note_pitch[i] <= '0;
            end
        end else if (state == CLEAR) begin
            note_code[clr_cnt]  <= '0;
            note_pitch[clr_cnt] <= '0;
        end else if (wr_ok) begin
            note_code[wr_slot]  <= wr_code;
            note_pitch[wr_slot] <= wr_pitch;
        end
    end

    // Stage-1 registers feeding the glyph ROM address
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_hit   <= 1'b0;
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_hit   <= hit;
            s1_valid <= pix_valid;
            s1_code  <= sel_code;
            s1_row   <= dy[2:0];
            s1_col   <= col;
        end
    end

    assign rom_addr = {s1_code, s1_row};

    // Stage-2: pick the glyph bit (bit 7 is the leftmost pixel, hence ~col)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            note_on    <= 1'b0;
            note_valid <= 1'b0;
        end else begin
            note_on    <= s1_valid & s1_hit & rom_data[~s1_col];
            note_valid <= s1_valid;
        end
    end

endmodule
